// File: rtl/alu_bus_pkg.sv
// Shared definitions for the ALU bus controller: opcodes, FSM state encoding
// and the default bus width.
package alu_bus_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_NOT     = 3'b101;
  localparam logic [2:0] OP_XNOR    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_A = 3'd1,
    S_LD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with a global enable; all-zero when disabled.
module onehot_dec #(
  parameter int NREG  = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  onehot
);

  // Decode the index into a single asserted bit when enabled
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_bus_controller.sv
// Bus-side initiator sequencing register drivers, ALU operand strobes, ALU
// select and ALU output enable so one register-to-register op completes per
// request. Every output is registered: the output logic works from the next
// state so the registered values line up with the state they belong to.
// Optional feature macro: ALU_CTRL_IMM_EN (immediate B operand via bus_out).
module alu_bus_controller
  import alu_bus_pkg::*;
#(
`ifdef ALU_CTRL_IMM_EN
  parameter int DATA_W = alu_bus_pkg::DEFAULT_DATA_W,
`endif
  parameter int NREG  = 4,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [IDX_W-1:0] src_a,
  input  logic [IDX_W-1:0] src_b,
  input  logic [IDX_W-1:0] dst,
`ifdef ALU_CTRL_IMM_EN
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  output wire  [DATA_W-1:0] bus_out,
`endif
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [NREG-1:0]  reg_out_en,
  output logic [NREG-1:0]  reg_in_en,
  output logic             alu_a_in,
  output logic             alu_b_in,
  output logic [2:0]       alu_select,
  output logic             alu_out_en
);

  state_t state, next_state;

  logic [2:0]       op_q;
  logic [IDX_W-1:0] src_a_q, src_b_q, dst_q;
  logic             accept, illegal, imm_sel;

  // In IDLE the request fields are not captured yet, so LD_A outputs come
  // straight from the inputs; afterwards they come from the captured copy.
  logic [2:0]       eff_op;
  logic [IDX_W-1:0] eff_src_a;

  logic [IDX_W-1:0] out_idx;
  logic             out_en, in_en;
  logic [NREG-1:0]  reg_out_d, reg_in_d;
  logic             ready_d, done_d, err_d, a_in_d, b_in_d, alu_out_en_d;
  logic [2:0]       sel_d;

  assign accept    = (state == S_IDLE) && start && (op != OP_ILLEGAL);
  assign illegal   = (state == S_IDLE) && start && (op == OP_ILLEGAL);
  assign eff_op    = (state == S_IDLE) ? op    : op_q;
  assign eff_src_a = (state == S_IDLE) ? src_a : src_a_q;

`ifdef ALU_CTRL_IMM_EN
  logic              use_imm_q, imm_drv_d, imm_drv;
  logic [DATA_W-1:0] imm_q;
  assign imm_sel = use_imm_q;
  assign bus_out = imm_drv ? imm_q : {DATA_W{1'bz}};

  // Capture the immediate operand with the request
  always_ff @(posedge clk) begin
    if (accept) begin
      use_imm_q <= use_imm;
      imm_q     <= imm;
    end
  end

  // Immediate bus drive flag, cleared by reset so bus_out floats
  always_ff @(posedge clk) begin
    if (reset) imm_drv <= 1'b0;
    else       imm_drv <= imm_drv_d;
  end
`else
  assign imm_sel = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Capture request fields on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op;
      src_a_q <= src_a;
      src_b_q <= src_b;
      dst_q   <= dst;
    end
  end

  // Next-state logic; NOT has no B operand and skips LD_B
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_LD_A;
      S_LD_A:  next_state = (op_q == OP_NOT) ? S_EXEC : S_LD_B;
      S_LD_B:  next_state = S_EXEC;
      S_EXEC:  next_state = S_WB;
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic for the coming cycle; one bus driver at most per state
  always_comb begin
    out_idx      = src_b_q;
    out_en       = 1'b0;
    in_en        = (next_state == S_WB);
    a_in_d       = 1'b0;
    b_in_d       = 1'b0;
    alu_out_en_d = 1'b0;
    ready_d      = (next_state == S_IDLE);
    done_d       = (state == S_WB);
    err_d        = illegal;
    sel_d        = (next_state != S_IDLE) ? eff_op : alu_select;
`ifdef ALU_CTRL_IMM_EN
    imm_drv_d    = 1'b0;
`endif
    case (next_state)
      S_LD_A: begin
        out_idx = eff_src_a;
        out_en  = 1'b1;
        a_in_d  = 1'b1;
      end
      S_LD_B: begin
        out_en  = !imm_sel;
        b_in_d  = 1'b1;
`ifdef ALU_CTRL_IMM_EN
        imm_drv_d = imm_sel;
`endif
      end
      S_WB:    alu_out_en_d = 1'b1;
      default: ;
    endcase
  end

  onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_out_dec (
    .idx    (out_idx),
    .en     (out_en),
    .onehot (reg_out_d)
  );

  onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_in_dec (
    .idx    (dst_q),
    .en     (in_en),
    .onehot (reg_in_d)
  );

  // Output registers; reset drops every enable and reports ready
  always_ff @(posedge clk) begin
    if (reset) begin
      ready      <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      reg_out_en <= '0;
      reg_in_en  <= '0;
      alu_a_in   <= 1'b0;
      alu_b_in   <= 1'b0;
      alu_select <= 3'b000;
      alu_out_en <= 1'b0;
    end else begin
      ready      <= ready_d;
      done       <= done_d;
      err        <= err_d;
      reg_out_en <= reg_out_d;
      reg_in_en  <= reg_in_d;
      alu_a_in   <= a_in_d;
      alu_b_in   <= b_in_d;
      alu_select <= sel_d;
      alu_out_en <= alu_out_en_d;
    end
  end

endmodule

// File: tb/tb_alu_bus_controller.sv
// Bench: controller wired to a 4-register file, an ALU with A/B latches and a
// shared bus modelled as the OR of the active drivers.
module tb_alu_bus_controller;
  import alu_bus_pkg::*;

  localparam int NREG = 4;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [1:0]  src_a, src_b, dst;
  logic        ready, done, err, alu_a_in, alu_b_in, alu_out_en;
  logic [3:0]  reg_out_en, reg_in_en;
  logic [2:0]  alu_select;
`ifdef ALU_CTRL_IMM_EN
  logic        use_imm;
  logic [15:0] imm;
  wire  [15:0] bus_out;
`endif

  alu_bus_controller dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .dst        (dst),
`ifdef ALU_CTRL_IMM_EN
    .use_imm    (use_imm),
    .imm        (imm),
    .bus_out    (bus_out),
`endif
    .ready      (ready),
    .done       (done),
    .err        (err),
    .reg_out_en (reg_out_en),
    .reg_in_en  (reg_in_en),
    .alu_a_in   (alu_a_in),
    .alu_b_in   (alu_b_in),
    .alu_select (alu_select),
    .alu_out_en (alu_out_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- environment: register file, ALU, bus ----------------
  logic [15:0] rf [NREG];
  logic [15:0] load_vals [NREG];
  logic        load_en;
  logic [15:0] alu_a, alu_b, alu_res, bus;
  int          ndrv;

  function automatic logic [15:0] alu_fn(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return ~(a ^ b);
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_select, alu_a, alu_b);

  always_comb begin
    bus  = 16'h0000;
    ndrv = 0;
    for (int i = 0; i < NREG; i++)
      if (reg_out_en[i]) begin
        bus  = bus | rf[i];
        ndrv = ndrv + 1;
      end
    if (alu_out_en) begin
      bus  = bus | alu_res;
      ndrv = ndrv + 1;
    end
`ifdef ALU_CTRL_IMM_EN
    if (bus_out !== 16'hzzzz) begin
      bus  = bus | bus_out;
      ndrv = ndrv + 1;
    end
`endif
  end

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < NREG; i++) rf[i] <= load_vals[i];
    end else begin
      for (int i = 0; i < NREG; i++) if (reg_in_en[i]) rf[i] <= bus;
    end
    if (alu_a_in) alu_a <= bus;
    if (alu_b_in) alu_b <= bus;
  end

  // Bus ownership invariant checked every cycle
  always @(negedge clk) begin
    checks = checks + 1;
    if (ndrv > 1 || (reg_in_en != 4'b0000 && !alu_out_en)) begin
      errors = errors + 1;
      $display("FAIL bus_invariant drivers=%0d reg_in_en=%b alu_out_en=%b", ndrv, reg_in_en, alu_out_en);
    end
  end

  // ---------------- reference model (spec-level result rules) ----------------
  function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua, ub;
    ua = a;
    ub = b;
    case (o)
      OP_ADD:  return 16'((ua + ub) % 65536);
      OP_SUB:  return 16'((ua + 65536 - ub) % 65536);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return 16'(65535 - ua);
      default: return 16'(65535 - (ua ^ ub));
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3);
    load_vals[0] = v0; load_vals[1] = v1; load_vals[2] = v2; load_vals[3] = v3;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  // Issue one request from an IDLE cycle and follow it to done (bounded)
  task automatic run_op(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                        output int lat, output int na, output int nb, output int ne, output logic [2:0] sel1);
    op = o; src_a = a; src_b = b; dst = d; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; na = 0; nb = 0; ne = 0;
    sel1 = alu_select;
    while (!done && lat < 12) begin
      na += int'(alu_a_in);
      nb += int'(alu_b_in);
      ne += int'(err);
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  a, b, d;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] mdl [NREG];
  int          lat, na, nb, ne, cnt;
  logic [2:0]  sel1;
  logic [2:0]  ro;
  logic [1:0]  ra, rb, rd;
  logic [15:0] expv;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; src_a = 2'd0; src_b = 2'd0; dst = 2'd0;
    load_en = 1'b0;
    for (int i = 0; i < NREG; i++) load_vals[i] = 16'h0000;
`ifdef ALU_CTRL_IMM_EN
    use_imm = 1'b0; imm = 16'h0000;
`endif
    // Common register contents for the table: R0=5 R1=3 R2=1234 R3=00FF
    vecs[0] = '{OP_ADD,  2'd0, 2'd1, 2'd2, 16'h0008, 5};
    vecs[1] = '{OP_SUB,  2'd1, 2'd0, 2'd3, 16'hFFFE, 5};
    vecs[2] = '{OP_XNOR, 2'd0, 2'd0, 2'd2, 16'hFFFF, 5};
    vecs[3] = '{OP_NOT,  2'd0, 2'd3, 2'd1, 16'hFFFA, 4};
    vecs[4] = '{OP_AND,  2'd2, 2'd3, 2'd0, 16'h0034, 5};
    vecs[5] = '{OP_OR,   2'd2, 2'd3, 2'd1, 16'h12FF, 5};
    vecs[6] = '{OP_XOR,  2'd2, 2'd3, 2'd3, 16'h12CB, 5};
    vecs[7] = '{OP_ADD,  2'd3, 2'd3, 2'd3, 16'h01FE, 5};

    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_reg_en", {24'd0, reg_out_en, reg_in_en}, 32'd0);
    chk("rst_alu_strobes", {29'd0, alu_a_in, alu_b_in, alu_out_en}, 32'd0);
    chk("rst_alu_select", {29'd0, alu_select}, 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven directed ops
    for (int i = 0; i < 8; i++) begin
      load(16'h0005, 16'h0003, 16'h1234, 16'h00FF);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, lat, na, nb, ne, sel1);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_result", i), {16'd0, rf[vecs[i].d]}, {16'd0, vecs[i].exp});
      chk($sformatf("vec%0d_a_pulses", i), na, 1);
      chk($sformatf("vec%0d_b_pulses", i), nb, (vecs[i].op == OP_NOT) ? 0 : 1);
      chk($sformatf("vec%0d_select", i), {29'd0, sel1}, {29'd0, vecs[i].op});
      chk($sformatf("vec%0d_ready_at_done", i), {30'd0, ready, ne != 0}, 32'd2);
      tick();
    end

    // Illegal opcode: err next cycle, nothing enabled, stays ready
    op = OP_ILLEGAL; src_a = 2'd0; src_b = 2'd1; dst = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_ready", {31'd0, ready}, 32'd1);
    chk("illegal_enables", {21'd0, reg_out_en, reg_in_en, alu_a_in, alu_b_in, alu_out_en}, 32'd0);
    tick();
    chk("illegal_err_pulse", {30'd0, err, done}, 32'd0);
    chk("illegal_idle", {31'd0, alu_a_in}, 32'd0);

    // Start during LD_B is ignored
    load(16'h0005, 16'h0003, 16'h0000, 16'h0000);
    op = OP_ADD; src_a = 2'd0; src_b = 2'd1; dst = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("busy_in_ldb", {30'd0, alu_b_in, ready}, 32'd2);
    op = OP_XOR; dst = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 10) begin tick(); cnt++; end
    chk("busy_first_done", {31'd0, done}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); cnt += int'(alu_a_in) + int'(done); end
    chk("busy_no_second_op", cnt, 0);
    chk("busy_r2", {16'd0, rf[2]}, 32'h0008);
    chk("busy_r3_untouched", {16'd0, rf[3]}, 32'h0000);

    // Reset while in EXEC
    load(16'h0005, 16'h0003, 16'h0000, 16'h7777);
    op = OP_SUB; src_a = 2'd0; src_b = 2'd1; dst = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("exec_quiet", {21'd0, reg_out_en, reg_in_en, alu_a_in, alu_b_in, alu_out_en}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_enables", {21'd0, reg_out_en, reg_in_en, alu_a_in, alu_b_in, alu_out_en}, 32'd0);
    chk("midrst_ready_done", {30'd0, ready, done}, 32'd2);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); cnt += int'(done) + int'(alu_out_en); end
    chk("midrst_no_done", cnt, 0);
    chk("midrst_dst_kept", {16'd0, rf[3]}, 32'h7777);

`ifdef ALU_CTRL_IMM_EN
    // Immediate B operand via bus_out
    load(16'h0FFF, 16'h1111, 16'h0000, 16'h0000);
    use_imm = 1'b1; imm = 16'h00F0;
    op = OP_AND; src_a = 2'd0; src_b = 2'd1; dst = 2'd2; start = 1'b1;
    tick();
    start = 1'b0; use_imm = 1'b0;
    cnt = 0; lat = 1;
    while (!done && lat < 12) begin
      if (bus_out !== 16'hzzzz) begin
        cnt++;
        chk("imm_only_in_ldb", {31'd0, alu_b_in}, 32'd1);
        chk("imm_no_reg_drv", {28'd0, reg_out_en}, 32'd0);
      end
      tick();
      lat++;
    end
    chk("imm_drive_cycles", cnt, 1);
    chk("imm_result", {16'd0, rf[2]}, 32'h00F0);
    tick();
`endif

    // Randomized ops against the reference model, sometimes back-to-back
    for (int i = 0; i < NREG; i++) mdl[i] = 16'($urandom);
    load(mdl[0], mdl[1], mdl[2], mdl[3]);
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      rd = 2'($urandom_range(0, 3));
      if (ro == OP_ILLEGAL) begin
        op = ro; src_a = ra; src_b = rb; dst = rd; start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("rnd%0d_err", n), {30'd0, err, ready}, 32'd3);
        tick();
      end else begin
        expv = ref_result(ro, mdl[ra], mdl[rb]);
        mdl[rd] = expv;
        run_op(ro, ra, rb, rd, lat, na, nb, ne, sel1);
        chk($sformatf("rnd%0d_latency", n), lat, (ro == OP_NOT) ? 4 : 5);
        for (int r = 0; r < NREG; r++)
          chk($sformatf("rnd%0d_r%0d", n, r), {16'd0, rf[r]}, {16'd0, mdl[r]});
        if ($urandom_range(0, 1) == 1) tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
